// File: rtl/sof_pkg.sv
// Shared constants and FSM encoding for the softmax decision stage.
// Both the RTL and the benches pull frame geometry from here.
package sof_pkg;

  localparam int NCLASS = 13;
  localparam int DW     = 11;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/top2_track.sv
// Running top-2 tracker over one frame of class scores.
// Outputs include the score presented this cycle, so the caller can latch the final result on the last element.
module top2_track
  import sof_pkg::*;
#(
  parameter int DW = sof_pkg::DW
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             valid,
  input  logic [IDX_W-1:0] count,
  input  logic [DW-1:0]    score,
  output logic [DW-1:0]    best,
  output logic [DW-1:0]    second,
  output logic [IDX_W-1:0] idx
);

  logic [DW-1:0]    best_q;
  logic [DW-1:0]    second_q;
  logic [IDX_W-1:0] idx_q;

  // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    best   = best_q;
    second = second_q;
    idx    = idx_q;
    if (valid) begin
      if (count == '0) begin
        best   = score;
        second = '0;
        idx    = '0;
      end else if (score > best_q) begin
        // Strict compare keeps the earliest index on ties.
        second = best_q;
        best   = score;
        idx    = count;
      end else if (score > second_q) begin
        second = score;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      best_q   <= '0;
      second_q <= '0;
      idx_q    <= '0;
    end else if (valid) begin
      best_q   <= best;
      second_q <= second;
      idx_q    <= idx;
    end
  end

endmodule

// File: rtl/sof_decide.sv
// Per-frame argmax decision over softmax scores, plus a run-length smoother
// that flags a word once the same confident class repeats HOLD frames in a row.
module sof_decide
  import sof_pkg::*;
#(
  parameter int             NCLASS = sof_pkg::NCLASS,
  parameter int             DW     = sof_pkg::DW,
  parameter logic [DW-1:0]  THRESH = DW'(1024),
  parameter int             HOLD   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dv_in,
  input  logic [DW-1:0]    prob_in,
  output logic             dv_out,
  output logic [3:0]       class_idx,
  output logic [DW-1:0]    class_prob,
  output logic [DW-1:0]    margin,
  output logic             frame_err,
  output logic             word_det,
  output logic [3:0]       word_idx
);

  localparam int RW = $clog2(HOLD) + 1;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] elem;
  logic             last;
  logic [DW-1:0]    best;
  logic [DW-1:0]    second;
  logic [IDX_W-1:0] idx;
  logic [RW-1:0]    run;
  logic [RW-1:0]    run_nxt;
  logic [3:0]       last_idx;
  logic             conf;
  logic             same;
  logic             det;

  top2_track #(.DW(DW)) u_top2 (
    .clk    (clk),
    .clear  (rst),
    .valid  (dv_in),
    .count  (elem),
    .score  (prob_in),
    .best   (best),
    .second (second),
    .idx    (idx)
  );

  // Any score arriving outside ACC starts a new frame, which gives back-to-back frames for free.
  always_comb begin
    elem    = (state == S_ACC) ? cnt : '0;
    last    = (elem == IDX_W'(NCLASS - 1));
    conf    = (class_prob >= THRESH);
    same    = (class_idx == last_idx);
    run_nxt = '0;
    if (conf) begin
      if (!same)                  run_nxt = RW'(1);
      else if (run == RW'(HOLD))  run_nxt = run;
      else                        run_nxt = run + RW'(1);
    end
    det = (run_nxt == RW'(HOLD)) && !(run == RW'(HOLD) && same);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dv_out     <= 1'b0;
      class_idx  <= '0;
      class_prob <= '0;
      margin     <= '0;
      frame_err  <= 1'b0;
      word_det   <= 1'b0;
      word_idx   <= '0;
      run        <= '0;
      last_idx   <= '0;
    end else begin
      dv_out    <= 1'b0;
      frame_err <= 1'b0;
      word_det  <= 1'b0;

      // Smoothing runs in the cycle dv_out is high, off the just-latched decision.
      if (state == S_EMIT) begin
        run <= run_nxt;
        if (conf) last_idx <= class_idx;
        if (det) begin
          word_det <= 1'b1;
          word_idx <= class_idx;
        end
      end

      if (dv_in) begin
        if (last) begin
          state      <= S_EMIT;
          cnt        <= '0;
          dv_out     <= 1'b1;
          class_idx  <= idx;
          class_prob <= best;
          margin     <= best - second;
        end else begin
          state <= S_ACC;
          cnt   <= elem + IDX_W'(1);
        end
      end else begin
        state <= S_IDLE;
        cnt   <= '0;
        if (state == S_ACC) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sof_decide.sv
// Directed bench for sof_decide: argmax, ties, back-to-back frames,
// word smoothing, short-frame discard and mid-frame reset.
module tb_sof_decide;
  import sof_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          dv_in;
  logic [DW-1:0] prob_in;
  logic          dv_out;
  logic [3:0]    class_idx;
  logic [DW-1:0] class_prob;
  logic [DW-1:0] margin;
  logic          frame_err;
  logic          word_det;
  logic [3:0]    word_idx;

  sof_decide dut (
    .clk        (clk),
    .rst        (rst),
    .dv_in      (dv_in),
    .prob_in    (prob_in),
    .dv_out     (dv_out),
    .class_idx  (class_idx),
    .class_prob (class_prob),
    .margin     (margin),
    .frame_err  (frame_err),
    .word_det   (word_det),
    .word_idx   (word_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int dv_q[$];
  int wd_cnt   = 0;
  int wd_cyc   = -1;
  int fe_cnt   = 0;
  int base;
  int wd0;
  logic [DW-1:0] frm [NCLASS];

  // Pulse recorder, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (dv_out === 1'b1) dv_q.push_back(cyc);
    if (word_det === 1'b1) begin
      wd_cnt++;
      wd_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      dv_in   = 1'b1;
      prob_in = frm[i];
      step();
    end
  endtask

  function automatic void set_frame(input int hi_idx, input int hi, input int lo);
    for (int i = 0; i < NCLASS; i++) frm[i] = DW'(lo);
    frm[hi_idx] = DW'(hi);
  endfunction

  // Full confident-or-not frame followed by one idle cycle.
  task automatic frame_gap();
    send_range(0, NCLASS);
    dv_in = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; dv_in = 1'b0; prob_in = '0;
    step(); step();
    check("rst_dv_out", dv_out, 0);
    check("rst_class_idx", class_idx, 0);
    check("rst_class_prob", class_prob, 0);
    check("rst_margin", margin, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_word_det", word_det, 0);
    check("rst_word_idx", word_idx, 0);
    rst = 1'b0;
    step();

    // Mixed frame: max 884 at idx 10, runner-up 870.
    frm = '{11'd667, 11'd286, 11'd502, 11'd846, 11'd113, 11'd454, 11'd870,
            11'd568, 11'd389, 11'd408, 11'd884, 11'd763, 11'd6};
    send_range(0, NCLASS - 1);
    check("mix_no_early_dv", dv_out, 0);
    send_range(NCLASS - 1, 1);
    dv_in = 1'b0;
    check("mix_dv_out", dv_out, 1);
    check("mix_class_idx", class_idx, 10);
    check("mix_class_prob", class_prob, 884);
    check("mix_margin", margin, 14);
    step();
    check("mix_dv_pulse_end", dv_out, 0);
    check("mix_hold_idx", class_idx, 10);
    check("mix_no_word", word_det, 0);

    // Tie at idx 2 and 7.
    set_frame(2, 900, 0);
    frm[7] = 11'd900;
    frame_gap();
    check("tie_class_idx", class_idx, 2);
    check("tie_class_prob", class_prob, 900);
    check("tie_margin", margin, 0);

    // Four back-to-back confident idx-5 frames.
    set_frame(5, 1500, 10);
    base = dv_q.size();
    send_range(0, NCLASS);
    check("b2b_dv_out", dv_out, 1);
    check("b2b_class_idx", class_idx, 5);
    check("b2b_class_prob", class_prob, 1500);
    check("b2b_margin", margin, 1490);
    send_range(0, NCLASS);
    send_range(0, NCLASS);
    check("b2b_dv3", dv_out, 1);
    check("b2b_no_word_yet", word_det, 0);
    send_range(0, NCLASS);
    dv_in = 1'b0;
    step(); step();
    check("b2b_dv_count", dv_q.size() - base, 4);
    check("b2b_spacing_12", dv_q[base+1] - dv_q[base], 13);
    check("b2b_spacing_23", dv_q[base+2] - dv_q[base+1], 13);
    check("b2b_word_count", wd_cnt, 1);
    check("b2b_word_timing", wd_cyc, dv_q[base+2] + 1);
    check("b2b_word_idx", word_idx, 5);

    // Run already saturated; a low frame must break it before a new word.
    wd0 = wd_cnt;
    frame_gap();
    frame_gap();
    set_frame(5, 800, 10);
    frame_gap();
    check("low_class_prob", class_prob, 800);
    check("low_margin", margin, 790);
    set_frame(5, 1500, 10);
    frame_gap();
    frame_gap();
    check("rebuild_no_word", wd_cnt, wd0);
    frame_gap();
    step();
    check("rebuild_word", wd_cnt, wd0 + 1);
    check("rebuild_word_idx", word_idx, 5);

    // Short frame between idx-9 confident frames must not disturb the run.
    set_frame(9, 1500, 10);
    frame_gap();
    frame_gap();
    set_frame(5, 1500, 10);
    base = dv_q.size();
    send_range(0, 7);
    dv_in = 1'b0;
    step();
    check("short_frame_err", frame_err, 1);
    check("short_no_dv", dv_out, 0);
    step();
    check("short_err_pulse_end", frame_err, 0);
    check("short_err_count", fe_cnt, 1);
    check("short_dv_count", dv_q.size() - base, 0);
    check("short_no_word", wd_cnt, wd0 + 1);
    set_frame(9, 1500, 10);
    frame_gap();
    step();
    check("short_after_idx", class_idx, 9);
    check("short_after_word", wd_cnt, wd0 + 2);
    check("short_after_word_idx", word_idx, 9);

    // Reset after 6 scores, then resume straight into a full frame.
    frm = '{11'd667, 11'd286, 11'd502, 11'd846, 11'd113, 11'd454, 11'd870,
            11'd568, 11'd389, 11'd408, 11'd884, 11'd763, 11'd6};
    base = dv_q.size();
    send_range(0, 6);
    rst = 1'b1;
    step();
    check("mrst_dv_out", dv_out, 0);
    check("mrst_frame_err", frame_err, 0);
    check("mrst_class_idx", class_idx, 0);
    check("mrst_class_prob", class_prob, 0);
    check("mrst_margin", margin, 0);
    check("mrst_word_idx", word_idx, 0);
    rst = 1'b0;
    send_range(0, NCLASS);
    dv_in = 1'b0;
    check("mrst_after_dv", dv_out, 1);
    check("mrst_after_idx", class_idx, 10);
    check("mrst_after_prob", class_prob, 884);
    check("mrst_after_margin", margin, 14);
    step();
    check("mrst_dv_count", dv_q.size() - base, 1);
    check("mrst_err_count", fe_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
